// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the execute stage.
// Shift-add multiply and restoring divide, one iteration per cycle, sign fix-up at the end.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_MUL  | shift-add multiply iterations
// S_DIV  | restoring shift-subtract divide iterations
// S_FIX  | sign correction, HI/LO write, done pulse
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rs_raw;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz_out;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_abs;
  logic [WIDTH-1:0]   w_rt_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_rs_neg = op[0] & rs_content[WIDTH-1];
  assign w_rt_neg = op[0] & rt_content[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -rs_content : rs_content;
  assign w_rt_abs = w_rt_neg ? -rt_content : rt_content;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_q_bit   = (w_rem_sh >= {1'b0, r_a});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_a;
  assign w_rem_nxt = w_q_bit ? w_rem_sub : w_rem_sh[WIDTH-1:0];

  assign w_prod_neg = -r_acc;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_acc     <= '0;
      r_rs_raw  <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= op[1] ? w_rt_abs : w_rs_abs;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_rs_abs : w_rt_abs)};
            r_rs_raw <= rs_content;
            r_is_div <= op[1];
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_dbz    <= op[1] & (rt_content == '0);
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
            r_state  <= op[1] ? S_DIV : S_MUL;
          end else begin
            if (mthi) r_hi <= rs_content;
            if (mtlo) r_lo <= rs_content;
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
          end else if (r_dbz) begin
            // Divide by zero reports the raw dividend, not its magnitude
            r_hi <= r_rs_raw;
            r_lo <= '1;
          end else begin
            r_hi <= r_neg_r ? -w_rem : w_rem;
            r_lo <= r_neg_q ? -w_quo : w_quo;
          end
          r_done    <= 1'b1;
          r_dbz_out <= r_dbz;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_content(rs_content), .rt_content(rt_content),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV truncating division
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    logic [63:0] up;
    longint sa, sb, sp, q, r;
    z = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    h = '0;
    l = '0;
    case (o)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      2'b01: begin sp = sa * sb; {h, l} = sp; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (o == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  // poke = {start, mthi, mtlo} asserted for one cycle, poke_cyc cycles after E0
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int poke_cyc, input logic [2:0] poke,
                        input logic mt_with_start);
    logic [31:0] eh, el;
    logic ez;
    int cyc;
    logic busy_drop;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    op = o; rs_content = a; rt_content = b; start = 1'b1;
    mthi = mt_with_start; mtlo = mt_with_start;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_content = $urandom; rt_content = $urandom; op = 2'($urandom_range(0, 3));
    chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
    cyc = 0;
    busy_drop = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == poke_cyc) begin
        {start, mthi, mtlo} = poke;
        rs_content = 32'hDEAD_BEEF; rt_content = 32'h0000_0003;
      end
      @(negedge clk);
      {start, mthi, mtlo} = 3'b000;
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) busy_drop = 1'b1;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_done;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_content = '0; rt_content = '0;
    mthi = 1'b0; mtlo = 1'b0;
    #3;
    chk("reset_state", {30'd0, busy, done, div_by_zero, hi, lo[30:0]}, 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    #10 reset = 1'b0;

    run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'b000, 1'b0);
    chk("multu_max_spec", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, -1, 3'b000, 1'b0);
    run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, -1, 3'b000, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, -1, 3'b000, 1'b0);
    chk("divu_100_7_spec", {hi, lo}, {32'd2, 32'd14});
    run_op("div_m7_2",   2'b11, 32'hFFFF_FFF9, 32'd2, -1, 3'b000, 1'b0);
    run_op("div_7_m2",   2'b11, 32'd7, 32'hFFFF_FFFE, -1, 3'b000, 1'b0);
    run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'b000, 1'b0);
    run_op("divu_by0",   2'b10, 32'd5, 32'd0, -1, 3'b000, 1'b0);
    run_op("div_by0",    2'b11, 32'hFFFF_FFF0, 32'd0, -1, 3'b000, 1'b0);

    run_op("restart_e5", 2'b00, 32'd1000, 32'd2000, 4, 3'b100, 1'b0);
    run_op("mthi_busy",  2'b10, 32'd12345, 32'd10, 9, 3'b010, 1'b0);
    run_op("mtlo_busy",  2'b01, 32'hFFFF_FF00, 32'd9, 20, 3'b001, 1'b0);

    @(negedge clk);
    mtlo = 1'b1; rs_content = 32'h1234_5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_idle", {hi, lo}, {32'hFFFF_FFFF, 32'h1234_5678});
    chk("mtlo_nodone", 64'(done), 64'd0);
    mthi = 1'b1; mtlo = 1'b1; rs_content = 32'hA5A5_5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});

    run_op("start_mt", 2'b00, 32'd6, 32'd7, -1, 3'b000, 1'b1);

    op = 2'b11; rs_content = 32'hFFFF_FF9C; rt_content = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {31'd0, busy, hi}, 64'd0);
    chk("async_reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, -1, 3'b000, 1'b0);
    chk("multu_3x4_spec", {hi, lo}, 64'd12);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d", i), ro, ra, rb, -1, 3'b000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
